// File: rtl/reaction_timer_if.sv
// rtl/reaction_timer_if.sv - button inputs and game outputs of the reaction timer
interface reaction_timer_if;
    logic        start;
    logic        react;
    logic [1:0]  state;
    logic [13:0] current_score;
    logic        led_go;
    logic        false_start;

    modport master (
        output start, react,
        input  state, current_score, led_go, false_start
    );

    modport slave (
        input  start, react,
        output state, current_score, led_go, false_start
    );
endinterface

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - round controller and millisecond score generator for the reaction game
module reaction_timer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_BITS   = 11,
    parameter int MAX_SCORE    = 9999
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    reaction_timer_if.slave bus
);
    localparam int DW = DELAY_BITS + 11;
    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_MEAS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [13:0]     score_q, score_d;
    logic            led_go_q, led_go_d;
    logic            false_start_q, false_start_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic [1:0]      done_cnt_q, done_cnt_d;
    logic [PW-1:0]   presc_q;
    logic            start_q, react_q;
    logic [15:0]     lfsr_q;

    logic start_rise, react_rise, ms_tick, lfsr_fb;

    assign start_rise = bus.start & ~start_q;
    assign react_rise = bus.react & ~react_q;
    assign ms_tick    = (presc_q == PW'(TICKS_PER_MS - 1));
    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        led_go_d      = led_go_q;
        false_start_d = false_start_q;
        delay_d       = delay_q;
        done_cnt_d    = 2'd0;
        case (state_q)
            S_IDLE: begin
                led_go_d = 1'b0;
                if (start_rise) begin
                    delay_d       = DW'(MIN_DELAY_MS) + DW'(lfsr_q[DELAY_BITS-1:0]);
                    score_d       = 14'd0;
                    false_start_d = 1'b0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (react_rise) begin
                    false_start_d = 1'b1;
                    score_d       = 14'(MAX_SCORE);
                    state_d       = S_DONE;
                end else if (ms_tick) begin
                    delay_d = delay_q - DW'(1);
                    if (delay_q <= DW'(1)) begin
                        state_d  = S_MEAS;
                        led_go_d = 1'b1;
                        score_d  = 14'd0;
                    end
                end
            end
            S_MEAS: begin
                // react beats a coincident tick, so the score is the one shown at the press
                if (react_rise) begin
                    state_d  = S_DONE;
                    led_go_d = 1'b0;
                end else if (ms_tick) begin
                    if (score_q + 14'd1 >= 14'(MAX_SCORE)) begin
                        score_d  = 14'(MAX_SCORE);
                        state_d  = S_DONE;
                        led_go_d = 1'b0;
                    end else begin
                        score_d = score_q + 14'd1;
                    end
                end
            end
            S_DONE: begin
                led_go_d = 1'b0;
                // hold DONE for two edges so the high-score updater can commit
                if (done_cnt_q != 2'd2) begin
                    done_cnt_d = done_cnt_q + 2'd1;
                end else begin
                    done_cnt_d = done_cnt_q;
                    if (start_rise) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q       <= S_IDLE;
            score_q       <= 14'd0;
            led_go_q      <= 1'b0;
            false_start_q <= 1'b0;
            delay_q       <= '0;
            done_cnt_q    <= 2'd0;
            presc_q       <= '0;
            start_q       <= 1'b0;
            react_q       <= 1'b0;
            lfsr_q        <= 16'hACE1;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            led_go_q      <= led_go_d;
            false_start_q <= false_start_d;
            delay_q       <= delay_d;
            done_cnt_q    <= done_cnt_d;
            start_q       <= bus.start;
            react_q       <= bus.react;
            lfsr_q        <= {lfsr_q[14:0], lfsr_fb};
            // restart the millisecond grid on every state change
            if (state_d != state_q || ms_tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    assign bus.state         = state_q;
    assign bus.current_score = score_q;
    assign bus.led_go        = led_go_q;
    assign bus.false_start   = false_start_q;
endmodule
